// File: rtl/atom_rvcore_pkg.sv
// Shared constants for the atomRVCORE execute/memory slice: opcodes,
// ALU operation codes and func3 encodings for branches, loads and stores.
package atom_rvcore_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [5:0] {
        ALU_ADD   = 6'd0,
        ALU_SUB   = 6'd1,
        ALU_SLL   = 6'd2,
        ALU_SLT   = 6'd3,
        ALU_SLTU  = 6'd4,
        ALU_XOR   = 6'd5,
        ALU_SRL   = 6'd6,
        ALU_SRA   = 6'd7,
        ALU_OR    = 6'd8,
        ALU_AND   = 6'd9,
        ALU_BEQ   = 6'd10,
        ALU_BNE   = 6'd11,
        ALU_BLT   = 6'd12,
        ALU_BGE   = 6'd13,
        ALU_BLTU  = 6'd14,
        ALU_BGEU  = 6'd15,
        ALU_PASSB = 6'd16
    } alu_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;

    // Integer op selection shared by R-type and I-type; alt is func7[5],
    // allow_sub is cleared for immediates so ADDI never becomes SUB.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3,
                                            input logic alt,
                                            input logic allow_sub);
        alu_op_e op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/atom_rvcore_exec_mem_if.sv
// Bundle of decode inputs and control/data outputs of the execute/memory
// block. slave is the block side, master the driving (decoder/bench) side.
interface atom_rvcore_exec_mem_if #(
    parameter int DATAWIDTH = 32,
    parameter int ALU_OP    = 6
);
    logic [6:0]           opcode_i;
    logic [2:0]           func3_i;
    logic [6:0]           func7_i;
    logic [DATAWIDTH-1:0] operand_A_i;
    logic [DATAWIDTH-1:0] operand_B_i;
    logic [31:0]          address_i;
    logic [31:0]          DT_i;

    logic I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o;
    logic RWR_EN_o, BE_o, JALRE_o, UJE_o, LUI_EN_o;
    logic IWR_EN_o, IR_EN_o, DWR_EN_o, DR_EN_o;
    logic PCrst_o, regrst_o;
    logic [ALU_OP-1:0]    ALUop_o;
    logic [DATAWIDTH-1:0] result_o;
    logic [31:0]          DT_o;

    modport slave (
        input  opcode_i, func3_i, func7_i, operand_A_i, operand_B_i, address_i, DT_i,
        output I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o,
        output RWR_EN_o, BE_o, JALRE_o, UJE_o, LUI_EN_o,
        output IWR_EN_o, IR_EN_o, DWR_EN_o, DR_EN_o, PCrst_o, regrst_o,
        output ALUop_o, result_o, DT_o
    );

    modport master (
        output opcode_i, func3_i, func7_i, operand_A_i, operand_B_i, address_i, DT_i,
        input  I_EN_o, R_EN_o, S_EN_o, SB_EN_o, U_EN_o, UJ_EN_o,
        input  RWR_EN_o, BE_o, JALRE_o, UJE_o, LUI_EN_o,
        input  IWR_EN_o, IR_EN_o, DWR_EN_o, DR_EN_o, PCrst_o, regrst_o,
        input  ALUop_o, result_o, DT_o
    );
endinterface

// File: rtl/atom_rvcore_alu.sv
// Combinational ALU: integer ops, branch compares (1/0 result) and PASSB.
module atom_rvcore_alu
    import atom_rvcore_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic [5:0]           i_op,
    input  logic [DATAWIDTH-1:0] i_a,
    input  logic [DATAWIDTH-1:0] i_b,
    output logic [DATAWIDTH-1:0] o_result
);
    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    // Select the operation; undefined codes yield zero.
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_SLL:   o_result = i_a << w_shamt;
            ALU_SLT:   o_result = {{(DATAWIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU:  o_result = {{(DATAWIDTH-1){1'b0}}, (i_a < i_b)};
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SRL:   o_result = i_a >> w_shamt;
            ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:    o_result = i_a | i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_BEQ:   o_result = {{(DATAWIDTH-1){1'b0}}, (i_a == i_b)};
            ALU_BNE:   o_result = {{(DATAWIDTH-1){1'b0}}, (i_a != i_b)};
            ALU_BLT:   o_result = {{(DATAWIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_BGE:   o_result = {{(DATAWIDTH-1){1'b0}}, ($signed(i_a) >= $signed(i_b))};
            ALU_BLTU:  o_result = {{(DATAWIDTH-1){1'b0}}, (i_a < i_b)};
            ALU_BGEU:  o_result = {{(DATAWIDTH-1){1'b0}}, (i_a >= i_b)};
            ALU_PASSB: o_result = i_b;
            default:   o_result = '0;
        endcase
    end
endmodule

// File: rtl/atom_rvcore_dccm.sv
// Data closely-coupled memory: combinational read with byte/half/word
// extraction, synchronous byte-lane write. Contents survive reset.
module atom_rvcore_dccm
    import atom_rvcore_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic        clk_i,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic          w_unused_addr;

    // Upper address bits beyond the array simply wrap.
    assign w_idx         = i_addr[AW+1:2];
    assign w_unused_addr = ^i_addr[31:AW+2];
    assign w_word        = r_mem[w_idx];
    assign w_byte        = w_word[8*i_addr[1:0] +: 8];
    assign w_half        = i_addr[1] ? w_word[31:16] : w_word[15:0];

    // Load extraction and extension; zero when no load is decoded.
    always_comb begin
        o_rdata = '0;
        if (i_re) begin
            case (i_func3)
                F3_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
                F3_LBU:  o_rdata = {24'h0, w_byte};
                F3_LH:   o_rdata = {{16{w_half[15]}}, w_half};
                F3_LHU:  o_rdata = {16'h0, w_half};
                default: o_rdata = w_word;
            endcase
        end
    end

    // Byte-lane enables and lane-replicated write data for SB/SH/SW.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        case (i_func3)
            F3_SB: begin
                w_be            = 4'b0000;
                w_be[i_addr[1:0]] = 1'b1;
                w_wdata         = {4{i_wdata[7:0]}};
            end
            F3_SH: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

    // Write the enabled byte lanes on the rising edge.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: rtl/atom_rvcore_exec_mem.sv
// Execute/memory block of the single-cycle atomRVCORE: main control
// decoder, ALU, DCCM and the PC/register-file reset flop.
module atom_rvcore_exec_mem
    import atom_rvcore_pkg::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int ALU_OP     = 6,
    parameter int DCCM_DEPTH = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    atom_rvcore_exec_mem_if.slave   bus
);
    logic                 r_rst;
    logic                 w_i_en, w_r_en, w_s_en, w_sb_en, w_u_en, w_uj_en;
    logic                 w_rwr_en, w_jalre, w_uje, w_lui_en, w_dwr_en, w_dr_en;
    logic                 w_br_valid;
    alu_op_e              w_alu_op;
    logic [DATAWIDTH-1:0] w_result;
    logic                 w_unused_f7;

    assign w_unused_f7 = ^{bus.func7_i[6], bus.func7_i[4:0]};

    // Reset flop: set asynchronously, cleared on the first edge after release,
    // so PC and register file stay in reset for one extra cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rst <= 1'b1;
        end else begin
            r_rst <= 1'b0;
        end
    end

    // Main decoder: format/write enables and ALU op, all gated while in reset.
    always_comb begin
        w_i_en     = 1'b0;
        w_r_en     = 1'b0;
        w_s_en     = 1'b0;
        w_sb_en    = 1'b0;
        w_u_en     = 1'b0;
        w_uj_en    = 1'b0;
        w_rwr_en   = 1'b0;
        w_jalre    = 1'b0;
        w_uje      = 1'b0;
        w_lui_en   = 1'b0;
        w_dwr_en   = 1'b0;
        w_dr_en    = 1'b0;
        w_br_valid = 1'b0;
        w_alu_op   = ALU_ADD;
        if (!r_rst) begin
            case (bus.opcode_i)
                OP_R: begin
                    w_r_en   = 1'b1;
                    w_rwr_en = 1'b1;
                    w_alu_op = alu_from_f3(bus.func3_i, bus.func7_i[5], 1'b1);
                end
                OP_I: begin
                    w_i_en   = 1'b1;
                    w_rwr_en = 1'b1;
                    w_alu_op = alu_from_f3(bus.func3_i, bus.func7_i[5], 1'b0);
                end
                OP_LOAD: begin
                    w_i_en   = 1'b1;
                    w_rwr_en = 1'b1;
                    w_dr_en  = 1'b1;
                end
                OP_STORE: begin
                    w_s_en   = 1'b1;
                    w_dwr_en = 1'b1;
                end
                OP_BRANCH: begin
                    w_sb_en    = 1'b1;
                    w_br_valid = 1'b1;
                    case (bus.func3_i)
                        F3_BEQ:  w_alu_op = ALU_BEQ;
                        F3_BNE:  w_alu_op = ALU_BNE;
                        F3_BLT:  w_alu_op = ALU_BLT;
                        F3_BGE:  w_alu_op = ALU_BGE;
                        F3_BLTU: w_alu_op = ALU_BLTU;
                        F3_BGEU: w_alu_op = ALU_BGEU;
                        default: begin
                            w_alu_op   = ALU_ADD;
                            w_br_valid = 1'b0;
                        end
                    endcase
                end
                OP_LUI: begin
                    w_u_en   = 1'b1;
                    w_lui_en = 1'b1;
                    w_rwr_en = 1'b1;
                    w_alu_op = ALU_PASSB;
                end
                OP_AUIPC: begin
                    w_u_en   = 1'b1;
                    w_rwr_en = 1'b1;
                end
                OP_JAL: begin
                    w_uj_en  = 1'b1;
                    w_uje    = 1'b1;
                    w_rwr_en = 1'b1;
                end
                OP_JALR: begin
                    w_i_en   = 1'b1;
                    w_jalre  = 1'b1;
                    w_rwr_en = 1'b1;
                end
                default: begin
                    w_alu_op = ALU_ADD;
                end
            endcase
        end
    end

    atom_rvcore_alu #(
        .DATAWIDTH (DATAWIDTH)
    ) u_alu (
        .i_op     (w_alu_op),
        .i_a      (bus.operand_A_i),
        .i_b      (bus.operand_B_i),
        .o_result (w_result)
    );

    atom_rvcore_dccm #(
        .DEPTH (DCCM_DEPTH)
    ) u_dccm (
        .clk_i   (clk_i),
        .i_we    (w_dwr_en),
        .i_re    (w_dr_en),
        .i_func3 (bus.func3_i),
        .i_addr  (bus.address_i),
        .i_wdata (bus.DT_i),
        .o_rdata (bus.DT_o)
    );

    assign bus.I_EN_o   = w_i_en;
    assign bus.R_EN_o   = w_r_en;
    assign bus.S_EN_o   = w_s_en;
    assign bus.SB_EN_o  = w_sb_en;
    assign bus.U_EN_o   = w_u_en;
    assign bus.UJ_EN_o  = w_uj_en;
    assign bus.RWR_EN_o = w_rwr_en;
    assign bus.JALRE_o  = w_jalre;
    assign bus.UJE_o    = w_uje;
    assign bus.LUI_EN_o = w_lui_en;
    assign bus.DWR_EN_o = w_dwr_en;
    assign bus.DR_EN_o  = w_dr_en;
    assign bus.IWR_EN_o = 1'b0;
    assign bus.IR_EN_o  = ~r_rst;
    assign bus.PCrst_o  = r_rst;
    assign bus.regrst_o = r_rst;
    assign bus.ALUop_o  = ALU_OP'(w_alu_op);
    assign bus.result_o = w_result;
    // Reserved branch func3 codes fall back to ADD and must never take.
    assign bus.BE_o     = w_sb_en & w_br_valid & w_result[0];
endmodule

// File: tb/tb_atom_rvcore_exec_mem.sv
// Directed bench for atom_rvcore_exec_mem: decoder/ALU vector table,
// DCCM store/load sequences, and reset-flop behaviour.
module tb_atom_rvcore_exec_mem;

    localparam logic [11:0] EN_I     = 12'h800;
    localparam logic [11:0] EN_R     = 12'h400;
    localparam logic [11:0] EN_S     = 12'h200;
    localparam logic [11:0] EN_SB    = 12'h100;
    localparam logic [11:0] EN_U     = 12'h080;
    localparam logic [11:0] EN_UJ    = 12'h040;
    localparam logic [11:0] EN_RWR   = 12'h020;
    localparam logic [11:0] EN_JALRE = 12'h010;
    localparam logic [11:0] EN_UJE   = 12'h008;
    localparam logic [11:0] EN_LUI   = 12'h004;
    localparam logic [11:0] EN_DWR   = 12'h002;
    localparam logic [11:0] EN_DR    = 12'h001;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [5:0]  aluop;
        logic [11:0] en;
        logic        be;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];
    logic [31:0] exp_q[$];
    logic [11:0] w_en;

    atom_rvcore_exec_mem_if #(.DATAWIDTH(32), .ALU_OP(6)) bus ();

    atom_rvcore_exec_mem #(
        .DATAWIDTH  (32),
        .ALU_OP     (6),
        .DCCM_DEPTH (1024)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    assign w_en = {bus.I_EN_o, bus.R_EN_o, bus.S_EN_o, bus.SB_EN_o, bus.U_EN_o,
                   bus.UJ_EN_o, bus.RWR_EN_o, bus.JALRE_o, bus.UJE_o, bus.LUI_EN_o,
                   bus.DWR_EN_o, bus.DR_EN_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] addr, input logic [31:0] dt);
        bus.opcode_i    = op;
        bus.func3_i     = f3;
        bus.func7_i     = f7;
        bus.operand_A_i = a;
        bus.operand_B_i = b;
        bus.address_i   = addr;
        bus.DT_i        = dt;
    endtask

    task automatic add_vec(input string n, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [5:0] aluop,
                           input logic [11:0] en, input logic be);
        vec_t v;
        v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
        v.res = res; v.aluop = aluop; v.en = en; v.be = be;
        vecs.push_back(v);
    endtask

    // Store at the next edge: drive at a falling edge, let one rising edge pass.
    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] dt);
        @(negedge clk);
        drive(7'b0100011, f3, 7'h00, 32'h0, 32'h0, addr, dt);
        @(negedge clk);
        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    // Load check through the scoreboard queue.
    task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        drive(7'b0000011, f3, 7'h00, 32'h0, 32'h0, addr, 32'h0);
        #1;
        e = exp_q.pop_front();
        chk(name, bus.DT_o, e);
    endtask

    initial begin
        drive(7'b0110011, 3'b100, 7'h00, 32'd5, 32'd3, 32'h0, 32'h0);

        // Reset: enables gated, ALU forced to ADD (5+3=8, not XOR=6)
        #1 rst_i = 1'b1;
        #1;
        chk("rst_pcrst", {31'h0, bus.PCrst_o}, 32'h1);
        chk("rst_regrst", {31'h0, bus.regrst_o}, 32'h1);
        chk("rst_en", {20'h0, w_en}, 32'h0);
        chk("rst_ir_en", {31'h0, bus.IR_EN_o}, 32'h0);
        chk("rst_aluop", {26'h0, bus.ALUop_o}, 32'h0);
        chk("rst_result", bus.result_o, 32'd8);
        chk("rst_dt_o", bus.DT_o, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rst_hold_pcrst", {31'h0, bus.PCrst_o}, 32'h1);
        @(posedge clk);
        #1;
        chk("rst_clear_pcrst", {31'h0, bus.PCrst_o}, 32'h0);
        chk("rst_clear_ir_en", {31'h0, bus.IR_EN_o}, 32'h1);
        chk("xor_result", bus.result_o, 32'd6);

        // Decoder / ALU vector table
        add_vec("add",   7'b0110011, 3'b000, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 6'd0, EN_R | EN_RWR, 1'b0);
        add_vec("sub",   7'b0110011, 3'b000, 7'h20, 32'h0, 32'h1, 32'hFFFFFFFF, 6'd1, EN_R | EN_RWR, 1'b0);
        add_vec("xor",   7'b0110011, 3'b100, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 6'd5, EN_R | EN_RWR, 1'b0);
        add_vec("slt",   7'b0110011, 3'b010, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h1, 6'd3, EN_R | EN_RWR, 1'b0);
        add_vec("srl",   7'b0110011, 3'b101, 7'h00, 32'h80000000, 32'h4, 32'h08000000, 6'd6, EN_R | EN_RWR, 1'b0);
        add_vec("srai",  7'b0010011, 3'b101, 7'h20, 32'h80000000, 32'h4, 32'hF8000000, 6'd7, EN_I | EN_RWR, 1'b0);
        add_vec("sltiu", 7'b0010011, 3'b011, 7'h00, 32'h1, 32'hFFFFFFFF, 32'h1, 6'd4, EN_I | EN_RWR, 1'b0);
        add_vec("addi_f7", 7'b0010011, 3'b000, 7'h20, 32'h5, 32'h3, 32'h8, 6'd0, EN_I | EN_RWR, 1'b0);
        add_vec("blt",   7'b1100011, 3'b100, 7'h00, 32'hFFFFFFFE, 32'h1, 32'h1, 6'd12, EN_SB, 1'b1);
        add_vec("bgeu",  7'b1100011, 3'b111, 7'h00, 32'hFFFFFFFE, 32'h1, 32'h1, 6'd15, EN_SB, 1'b1);
        add_vec("beq",   7'b1100011, 3'b000, 7'h00, 32'h5, 32'h6, 32'h0, 6'd10, EN_SB, 1'b0);
        add_vec("br_rsv", 7'b1100011, 3'b010, 7'h00, 32'h1, 32'h2, 32'h3, 6'd0, EN_SB, 1'b0);
        add_vec("lui",   7'b0110111, 3'b000, 7'h00, 32'h0, 32'h12345000, 32'h12345000, 6'd16, EN_U | EN_LUI | EN_RWR, 1'b0);
        add_vec("auipc", 7'b0010111, 3'b000, 7'h00, 32'h1000, 32'h2000, 32'h3000, 6'd0, EN_U | EN_RWR, 1'b0);
        add_vec("jal",   7'b1101111, 3'b000, 7'h00, 32'h100, 32'h4, 32'h104, 6'd0, EN_UJ | EN_UJE | EN_RWR, 1'b0);
        add_vec("jalr",  7'b1100111, 3'b000, 7'h00, 32'h10, 32'h20, 32'h30, 6'd0, EN_I | EN_JALRE | EN_RWR, 1'b0);
        add_vec("unknown", 7'b1111111, 3'b000, 7'h00, 32'h7, 32'h9, 32'h10, 6'd0, 12'h000, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, 32'h0, 32'h0);
            #1;
            chk({vecs[i].name, "_result"}, bus.result_o, vecs[i].res);
            chk({vecs[i].name, "_aluop"}, {26'h0, bus.ALUop_o}, {26'h0, vecs[i].aluop});
            chk({vecs[i].name, "_en"}, {20'h0, w_en}, {20'h0, vecs[i].en});
            chk({vecs[i].name, "_be"}, {31'h0, bus.BE_o}, {31'h0, vecs[i].be});
            chk({vecs[i].name, "_iwr"}, {31'h0, bus.IWR_EN_o}, 32'h0);
        end

        // Load / store decode enables
        drive(7'b0100011, 3'b010, 7'h00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1 chk("store_en", {20'h0, w_en}, {20'h0, EN_S | EN_DWR});
        drive(7'b0000011, 3'b010, 7'h00, 32'h0, 32'h0, 32'h0, 32'h0);
        #1 chk("load_en", {20'h0, w_en}, {20'h0, EN_I | EN_RWR | EN_DR});

        // DCCM word store, then extended loads
        store(3'b010, 32'd8, 32'h8899AABB);
        load_chk("lw_8",   3'b010, 32'd8,  32'h8899AABB);
        load_chk("lb_9",   3'b000, 32'd9,  32'hFFFFFFAA);
        load_chk("lhu_10", 3'b101, 32'd10, 32'h00008899);
        load_chk("lh_8",   3'b001, 32'd8,  32'hFFFFAABB);
        load_chk("lbu_11", 3'b100, 32'd11, 32'h00000088);
        load_chk("lw_wrap", 3'b010, 32'd8 + 32'd4096, 32'h8899AABB);

        // Byte and halfword stores only touch their lanes
        store(3'b000, 32'd8, 32'h00000011);
        load_chk("lw_after_sb", 3'b010, 32'd8, 32'h8899AA11);
        store(3'b001, 32'd10, 32'h12345678);
        load_chk("lw_after_sh", 3'b010, 32'd8, 32'h5678AA11);

        drive(7'b0110011, 3'b000, 7'h00, 32'h0, 32'h0, 32'd8, 32'h0);
        #1 chk("dt_o_no_load", bus.DT_o, 32'h0);

        // Reset asserted mid-cycle with a store decoded: no write may happen
        @(negedge clk);
        drive(7'b0100011, 3'b010, 7'h00, 32'h0, 32'h0, 32'd8, 32'hDEADBEEF);
        #1 chk("pre_rst_dwr", {31'h0, bus.DWR_EN_o}, 32'h1);
        #1 rst_i = 1'b1;
        #1;
        chk("mid_rst_pcrst", {31'h0, bus.PCrst_o}, 32'h1);
        chk("mid_rst_regrst", {31'h0, bus.regrst_o}, 32'h1);
        chk("mid_rst_dwr", {31'h0, bus.DWR_EN_o}, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        #1 chk("mid_rst_hold", {31'h0, bus.PCrst_o}, 32'h1);
        @(posedge clk);
        #1;
        chk("mid_rst_clear", {31'h0, bus.PCrst_o}, 32'h0);
        load_chk("lw_after_rst", 3'b010, 32'd8, 32'h5678AA11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
